// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding, lamp patterns and direction codes for the intersection scheduler
// Lamp vector layout is {R1,Y1,G1,R2,Y2,G2,R3,G3}, bit7 = R1, active-high.
package traffic_pkg;

    localparam logic [2:0] ST_NS_G  = 3'd0;
    localparam logic [2:0] ST_NS_Y  = 3'd1;
    localparam logic [2:0] ST_EW_G  = 3'd2;
    localparam logic [2:0] ST_EW_Y  = 3'd3;
    localparam logic [2:0] ST_WALK  = 3'd4;
    localparam logic [2:0] ST_ALL_R = 3'd5;

    localparam logic [7:0] L_NS_G  = 8'h32;
    localparam logic [7:0] L_NS_Y  = 8'h52;
    localparam logic [7:0] L_EW_G  = 8'h86;
    localparam logic [7:0] L_EW_Y  = 8'h8A;
    localparam logic [7:0] L_WALK  = 8'h91;
    localparam logic [7:0] L_ALL_R = 8'h92;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    // Unused codes fall back to all-red so a corrupted state can never show a green.
    function automatic logic [7:0] lamps_of(input logic [2:0] s);
        return s == ST_NS_G ? L_NS_G :
               s == ST_NS_Y ? L_NS_Y :
               s == ST_EW_G ? L_EW_G :
               s == ST_EW_Y ? L_EW_Y :
               s == ST_WALK ? L_WALK : L_ALL_R;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// phase_timer: saturating elapsed-cycle counter with clear, enable and limit compare
// Ports: clk, reset (sync, active-high), clr (restart at 0), en (count this cycle),
//        limit (compare value), elapsed (current count), at_limit (elapsed == limit).
module phase_timer #(
    parameter int CNT_W = 29,
    parameter int SAT   = 4000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] elapsed,
    output logic             at_limit
);

    assign at_limit = elapsed == limit;

    // Sticks at SAT-1 so a green resting without competition cannot wrap.
    always_ff @(posedge clk) begin
        if (reset || clr)
            elapsed <= '0;
        else if (en && elapsed != CNT_W'(SAT - 1))
            elapsed <= elapsed + CNT_W'(1);
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: actuated NS/EW/pedestrian phase controller with latched requests
// Ports: clk, reset (sync, active-high), req_ns/req_ew (vehicle presence levels),
//        req_ped (button), hold (freeze timing and state), lamps {R1,Y1,G1,R2,Y2,G2,R3,G3},
//        phase (state code), ped_ack (one-cycle pulse on WALK entry).
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 1000,
    parameter int MAX_GREEN = 4000,
    parameter int YELLOW    = 500,
    parameter int ALL_RED   = 100,
    parameter int WALK      = 1000,
    parameter int CNT_W     = 29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       req_ped,
    input  logic       hold,
    output logic [7:0] lamps,
    output logic [2:0] phase,
    output logic       ped_ack
);

    logic [2:0]       state;
    logic [2:0]       nxt;
    logic [CNT_W-1:0] elapsed;
    logic [CNT_W-1:0] limit;
    logic             at_limit;
    logic             ns_pend;
    logic             ew_pend;
    logic             ped_pend;
    logic             last_dir;
    logic             from_walk;
    logic             min_ok;
    logic             ns_exit;
    logic             ew_exit;
    logic             go;
    logic             enter_walk;
    logic             enter_ns;
    logic             enter_ew;

    always_comb begin
        limit = state == ST_NS_Y || state == ST_EW_Y ? CNT_W'(YELLOW - 1) :
                state == ST_WALK                     ? CNT_W'(WALK - 1) :
                state == ST_ALL_R                    ? CNT_W'(ALL_RED - 1) :
                                                       CNT_W'(MAX_GREEN - 1);
    end

    // In a green, at_limit means the max-green bound has been reached.
    assign min_ok  = elapsed >= CNT_W'(MIN_GREEN - 1);
    assign ns_exit = (ew_pend || ped_pend) && ((min_ok && !req_ns) || at_limit);
    assign ew_exit = (ns_pend || ped_pend) && ((min_ok && !req_ew) || at_limit);

    always_comb begin
        nxt = hold                ? state :
              state == ST_NS_G    ? (ns_exit ? ST_NS_Y : ST_NS_G) :
              state == ST_EW_G    ? (ew_exit ? ST_EW_Y : ST_EW_G) :
              state == ST_NS_Y    ? (at_limit ? ST_ALL_R : ST_NS_Y) :
              state == ST_EW_Y    ? (at_limit ? ST_ALL_R : ST_EW_Y) :
              state == ST_WALK    ? (at_limit ? ST_ALL_R : ST_WALK) :
              !at_limit           ? ST_ALL_R :
              ped_pend && !from_walk ? ST_WALK :
              last_dir == DIR_NS  ? ST_EW_G : ST_NS_G;
    end

    assign go         = nxt != state;
    assign enter_walk = go && nxt == ST_WALK;
    assign enter_ns   = go && nxt == ST_NS_G;
    assign enter_ew   = go && nxt == ST_EW_G;

    phase_timer #(.CNT_W(CNT_W), .SAT(MAX_GREEN)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (go),
        .en       (~hold),
        .limit    (limit),
        .elapsed  (elapsed),
        .at_limit (at_limit)
    );

    // Set term is ORed after the clear so a request on the entry edge survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_NS_G;
            lamps     <= L_NS_G;
            ped_ack   <= 1'b0;
            ns_pend   <= 1'b0;
            ew_pend   <= 1'b0;
            ped_pend  <= 1'b0;
            last_dir  <= DIR_NS;
            from_walk <= 1'b0;
        end else begin
            state    <= nxt;
            lamps    <= lamps_of(nxt);
            ped_ack  <= enter_walk;
            ped_pend <= (req_ped && state != ST_WALK) || (ped_pend && !enter_walk);
            ew_pend  <= (req_ew && state != ST_EW_G) || (ew_pend && !enter_ew);
            ns_pend  <= (req_ns && state != ST_NS_G) || (ns_pend && !enter_ns);
            if (go && nxt == ST_ALL_R) begin
                last_dir  <= state == ST_EW_Y ? DIR_EW : state == ST_NS_Y ? DIR_NS : last_dir;
                from_walk <= state == ST_WALK;
            end
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: vector table, directed corner sequences and randomized model check
module tb_traffic_phase_scheduler;

    localparam int MIN = 10, MAXG = 40, YEL = 5, AR = 2, WLK = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1, req_ns = 1'b0, req_ew = 1'b0, req_ped = 1'b0, hold = 1'b0;
    logic [7:0] lamps;
    logic [2:0] phase;
    logic       ped_ack;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .MIN_GREEN(MIN), .MAX_GREEN(MAXG), .YELLOW(YEL), .ALL_RED(AR), .WALK(WLK), .CNT_W(6)
    ) dut (
        .clk(clk), .reset(reset), .req_ns(req_ns), .req_ew(req_ew), .req_ped(req_ped),
        .hold(hold), .lamps(lamps), .phase(phase), .ped_ack(ped_ack)
    );

    typedef struct {
        int         n;
        bit         rst, rn, re, rp, h, chk;
        logic [7:0] l;
        logic [2:0] p;
        bit         a;
        int         id;
    } row_t;

    row_t tbl[$];

    function automatic logic [7:0] lamp_pat(input int ph);
        case (ph)
            0: return 8'h32;
            1: return 8'h52;
            2: return 8'h86;
            3: return 8'h8A;
            4: return 8'h91;
            default: return 8'h92;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] el, input logic [2:0] ep, input bit ea);
        n_chk++;
        if (lamps !== el || phase !== ep || ped_ack !== ea) begin
            n_fail++;
            $display("FAIL %s t=%0t lamps=%h want %h phase=%0d want %0d ped_ack=%b want %b",
                     name, $time, lamps, el, phase, ep, ped_ack, ea);
        end
    endtask

    task automatic safety();
        n_chk++;
        if (((lamps[6] | lamps[5]) && (lamps[3] | lamps[2])) || (lamps[0] && phase != 3'd4)) begin
            n_fail++;
            $display("FAIL safety t=%0t lamps=%h phase=%0d", $time, lamps, phase);
        end
    endtask

    task automatic cyc(input string name, input bit rst, rn, re, rp, h, chk,
                       input logic [7:0] el, input logic [2:0] ep, input bit ea);
        reset = rst; req_ns = rn; req_ew = re; req_ped = rp; hold = h;
        if (chk) begin
            check(name, el, ep, ea);
            safety();
        end
        @(negedge clk);
    endtask

    task automatic add(input int n, input bit rst, rn, re, rp, h, chk,
                       input logic [7:0] l, input logic [2:0] p, input bit a, input int id);
        tbl.push_back('{n, rst, rn, re, rp, h, chk, l, p, a, id});
    endtask

    int m_ph, m_t;
    bit pn, pe, pp, m_last, m_fw, m_ack;

    task automatic mstep(input bit rst, rn, re, rp, h);
        int np;
        bit comp_ns, comp_ew;
        if (rst) begin
            m_ph = 0; m_t = 0; pn = 0; pe = 0; pp = 0; m_last = 0; m_fw = 0; m_ack = 0;
            return;
        end
        np = m_ph;
        comp_ns = pe || pp;
        comp_ew = pn || pp;
        if (!h) begin
            if (m_ph == 0 && comp_ns && ((m_t + 1 >= MIN && !rn) || m_t + 1 >= MAXG)) np = 1;
            if (m_ph == 2 && comp_ew && ((m_t + 1 >= MIN && !re) || m_t + 1 >= MAXG)) np = 3;
            if (m_ph == 1 && m_t + 1 == YEL) begin np = 5; m_last = 0; m_fw = 0; end
            if (m_ph == 3 && m_t + 1 == YEL) begin np = 5; m_last = 1; m_fw = 0; end
            if (m_ph == 4 && m_t + 1 == WLK) begin np = 5; m_fw = 1; end
            if (m_ph == 5 && m_t + 1 == AR) np = (pp && !m_fw) ? 4 : (m_last ? 0 : 2);
        end
        pp = (rp && m_ph != 4) || (pp && !(np == 4 && m_ph != 4));
        pe = (re && m_ph != 2) || (pe && !(np == 2 && m_ph != 2));
        pn = (rn && m_ph != 0) || (pn && !(np == 0 && m_ph != 0));
        m_ack = np == 4 && m_ph != 4;
        if (np != m_ph) m_t = 0;
        else if (!h && m_t < MAXG - 1) m_t++;
        m_ph = np;
    endtask

    initial begin
        bit rn, re, rp, h, rs;
        @(negedge clk);

        add(1,   1, 0, 0, 0, 0, 0, 8'h00, 3'd0, 0, 1);
        add(200, 0, 0, 0, 0, 0, 1, 8'h32, 3'd0, 0, 1);

        add(1,   1, 0, 0, 0, 0, 0, 8'h00, 3'd0, 0, 2);
        add(3,   0, 0, 0, 0, 0, 1, 8'h32, 3'd0, 0, 2);
        add(1,   0, 0, 1, 0, 0, 1, 8'h32, 3'd0, 0, 2);
        add(6,   0, 0, 0, 0, 0, 1, 8'h32, 3'd0, 0, 2);
        add(5,   0, 0, 0, 0, 0, 1, 8'h52, 3'd1, 0, 2);
        add(2,   0, 0, 0, 0, 0, 1, 8'h92, 3'd5, 0, 2);
        add(15,  0, 0, 0, 0, 0, 1, 8'h86, 3'd2, 0, 2);

        add(1,   0, 0, 0, 1, 0, 1, 8'h86, 3'd2, 0, 4);
        add(1,   0, 0, 0, 0, 0, 1, 8'h86, 3'd2, 0, 4);
        add(5,   0, 0, 0, 0, 0, 1, 8'h8A, 3'd3, 0, 4);
        add(2,   0, 0, 0, 0, 0, 1, 8'h92, 3'd5, 0, 4);
        add(1,   0, 0, 0, 0, 0, 1, 8'h91, 3'd4, 1, 4);
        add(7,   0, 0, 0, 0, 0, 1, 8'h91, 3'd4, 0, 4);
        add(2,   0, 0, 0, 0, 0, 1, 8'h92, 3'd5, 0, 4);
        add(3,   0, 0, 0, 0, 0, 1, 8'h32, 3'd0, 0, 4);

        add(1,   1, 1, 0, 0, 0, 0, 8'h00, 3'd0, 0, 3);
        add(3,   0, 1, 0, 0, 0, 1, 8'h32, 3'd0, 0, 3);
        add(1,   0, 1, 1, 0, 0, 1, 8'h32, 3'd0, 0, 3);
        add(36,  0, 1, 0, 0, 0, 1, 8'h32, 3'd0, 0, 3);
        add(5,   0, 1, 0, 0, 0, 1, 8'h52, 3'd1, 0, 3);
        add(2,   0, 1, 0, 0, 0, 1, 8'h92, 3'd5, 0, 3);
        add(10,  0, 1, 0, 0, 0, 1, 8'h86, 3'd2, 0, 3);
        add(1,   0, 1, 0, 0, 0, 1, 8'h8A, 3'd3, 0, 3);

        foreach (tbl[i])
            for (int k = 0; k < tbl[i].n; k++)
                cyc($sformatf("vec%0d_row%0d", tbl[i].id, i), tbl[i].rst, tbl[i].rn, tbl[i].re,
                    tbl[i].rp, tbl[i].h, tbl[i].chk, tbl[i].l, tbl[i].p, tbl[i].a);

        cyc("hold_rst", 1, 0, 0, 0, 0, 0, 8'h00, 3'd0, 0);
        cyc("hold_nsg", 0, 0, 1, 0, 0, 1, 8'h32, 3'd0, 0);
        repeat (9) cyc("hold_nsg", 0, 0, 0, 0, 0, 1, 8'h32, 3'd0, 0);
        repeat (3) cyc("hold_nsy", 0, 0, 0, 0, 0, 1, 8'h52, 3'd1, 0);
        repeat (7) cyc("hold_frz", 0, 0, 0, 0, 1, 1, 8'h52, 3'd1, 0);
        cyc("hold_ped", 0, 0, 0, 1, 1, 1, 8'h52, 3'd1, 0);
        repeat (12) cyc("hold_frz", 0, 0, 0, 0, 1, 1, 8'h52, 3'd1, 0);
        repeat (2) cyc("hold_tail", 0, 0, 0, 0, 0, 1, 8'h52, 3'd1, 0);
        repeat (2) cyc("hold_ar", 0, 0, 0, 0, 0, 1, 8'h92, 3'd5, 0);
        cyc("hold_walk0", 0, 0, 0, 0, 0, 1, 8'h91, 3'd4, 1);
        repeat (7) cyc("hold_walk", 0, 0, 0, 0, 0, 1, 8'h91, 3'd4, 0);
        repeat (2) cyc("hold_ar2", 0, 0, 0, 0, 0, 1, 8'h92, 3'd5, 0);
        repeat (3) cyc("hold_ewg", 0, 0, 0, 0, 0, 1, 8'h86, 3'd2, 0);

        cyc("wrst_rst", 1, 0, 0, 0, 0, 0, 8'h00, 3'd0, 0);
        cyc("wrst_nsg", 0, 0, 0, 1, 0, 1, 8'h32, 3'd0, 0);
        repeat (9) cyc("wrst_nsg", 0, 0, 0, 0, 0, 1, 8'h32, 3'd0, 0);
        repeat (5) cyc("wrst_nsy", 0, 0, 0, 0, 0, 1, 8'h52, 3'd1, 0);
        repeat (2) cyc("wrst_ar", 0, 0, 0, 0, 0, 1, 8'h92, 3'd5, 0);
        cyc("wrst_walk0", 0, 0, 1, 0, 0, 1, 8'h91, 3'd4, 1);
        cyc("wrst_walk1", 0, 0, 0, 0, 0, 1, 8'h91, 3'd4, 0);
        cyc("wrst_hit", 1, 0, 0, 0, 0, 1, 8'h91, 3'd4, 0);
        repeat (50) cyc("wrst_rest", 0, 0, 0, 0, 0, 1, 8'h32, 3'd0, 0);

        rn = 0; re = 0; h = 0;
        cyc("rand_rst", 1, 0, 0, 0, 0, 0, 8'h00, 3'd0, 0);
        mstep(1, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            check($sformatf("rand_c%0d", c), lamp_pat(m_ph), 3'(m_ph), m_ack);
            safety();
            if ($urandom_range(39) == 0) rn = ~rn;
            if ($urandom_range(39) == 0) re = ~re;
            if ($urandom_range(49) == 0) h = ~h;
            rp = $urandom_range(59) == 0;
            rs = $urandom_range(799) == 0;
            reset = rs; req_ns = rn; req_ew = re; req_ped = rp; hold = h;
            mstep(rs, rn, re, rp, h);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
